board_mem_arbiter: RTL and testbench

- Shares the single-port board-state RAM between three requesters:
  - the game-referee writer (port 0), which marks drawn edges;
  - the player-A move planner's memory reader (port 1);
  - the player-B move planner's memory reader (port 2).
- Port 0 has fixed priority. Ports 1 and 2 are round-robin.
- Readers may lock the RAM for a neighbourhood burst so that a 25-cell window read is atomic with respect to writes.
- Read data is routed back to the issuing port using an in-flight tag pipeline.

---
 rtl/board_mem_arbiter_if.sv | 50 +++++
 rtl/board_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// board_mem_arbiter_if
//   Bundles the three requester ports and the board-state RAM bus that the
//   arbiter sits between.
//
//   Requester side : req0..2, addr0..2, we0, wdata0, lock1..2 (to arbiter)
//                    gnt0..2, rdata0..2, rvalid0..2           (from arbiter)
//   RAM side       : mem_en, mem_we, mem_addr, mem_wdata      (from arbiter)
//                    mem_rdata                                (to arbiter)
//   Status         : owner (current lock holder), busy        (from arbiter)
//
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus the RAM).
// ----------------------------------------------------------------------------
interface board_mem_arbiter_if #(
    parameter int AW = 16
);
    logic          req0, req1, req2;
    logic [AW-1:0] addr0, addr1, addr2;
    logic          we0;
    logic [7:0]    wdata0;
    logic          lock1, lock2;

    logic          gnt0, gnt1, gnt2;
    logic [7:0]    rdata0, rdata1, rdata2;
    logic          rvalid0, rvalid1, rvalid2;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [1:0]    owner;
    logic          busy;

    modport slave (
        input  req0, req1, req2, addr0, addr1, addr2, we0, wdata0, lock1, lock2,
        input  mem_rdata,
        output gnt0, gnt1, gnt2, rdata0, rdata1, rdata2, rvalid0, rvalid1, rvalid2,
        output mem_en, mem_we, mem_addr, mem_wdata, owner, busy
    );

    modport master (
        output req0, req1, req2, addr0, addr1, addr2, we0, wdata0, lock1, lock2,
        output mem_rdata,
        input  gnt0, gnt1, gnt2, rdata0, rdata1, rdata2, rvalid0, rvalid1, rvalid2,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner, busy
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// ----------------------------------------------------------------------------
// board_mem_arbiter
//   Shares the single-port board-state RAM between the referee writer
//   (port 0, fixed priority) and the two move-planner readers (ports 1 and 2,
//   round-robin). A reader may lock the RAM so a neighbourhood window read is
//   atomic against writes; a lock is force-released for one arbitration cycle
//   after MAX_LOCK owner transfers so a pending write cannot starve.
//   Read data is steered back to the issuing port by a tag shift register
//   that tracks the RAM read latency.
//
//   Parameters : RD_LAT   RAM read latency, 1..3 cycles
//                MAX_LOCK max owner transfers under one lock
//                AW       address width
//   Ports      : clk, rst_n (async, active low)
//                bus      board_mem_arbiter_if.slave (requesters + RAM)
// ----------------------------------------------------------------------------
module board_mem_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 32,
    parameter int AW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    board_mem_arbiter_if.slave  bus
);
    localparam int             CW         = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0]  LOCK_LIMIT = CW'(MAX_LOCK);

    // Lock owner doubles as the lock FSM state: NONE = UNLOCKED.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P1   = 2'd1;
    localparam logic [1:0] OWN_P2   = 2'd2;

    // Return tags carried alongside each issued transfer.
    localparam logic [1:0] TAG_NONE = 2'd0;   // write or empty slot
    localparam logic [1:0] TAG_P1   = 2'd1;
    localparam logic [1:0] TAG_P2   = 2'd2;
    localparam logic [1:0] TAG_P0   = 2'd3;   // port 0 read

    logic          rr_prefer2;                // 0: port 1 wins a tie
    logic [1:0]    owner_q;
    logic [CW-1:0] lock_cnt;
    logic [1:0]    tag_q [RD_LAT+1];

    logic          owner_lock, locked_now;
    logic          gnt0, gnt1, gnt2, any_gnt;
    logic [AW-1:0] win_addr;
    logic [1:0]    push_tag, ret_tag;
    logic          tag_live;

    // ------------------------------------------------------------------
    // Grant selection. A lock only binds while the owner keeps its lock
    // line high and has not used up its transfer budget; the cycle the
    // lock drops (or the budget runs out) is already a free cycle, so a
    // waiting write is granted immediately.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
        owner_lock = (owner_q == OWN_P1 && bus.lock1) ||
                     (owner_q == OWN_P2 && bus.lock2);
        locked_now = owner_lock && (lock_cnt < LOCK_LIMIT);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        // Grants are gated by reset so every output is low while rst_n is low.
        if (rst_n) begin
            if (locked_now) begin
                gnt1 = (owner_q == OWN_P1) && bus.req1;
                gnt2 = (owner_q == OWN_P2) && bus.req2;
            end else if (bus.req0) begin
                gnt0 = 1'b1;
            end else if (bus.req1 && bus.req2) begin
                gnt1 = !rr_prefer2;
                gnt2 = rr_prefer2;
            end else begin
                gnt1 = bus.req1;
                gnt2 = bus.req2;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1 | gnt2;

    // Winner's address and the tag it pushes into the return pipeline.
    always_comb begin
        win_addr = bus.addr0;
        push_tag = TAG_NONE;
        if (gnt0) begin
            push_tag = bus.we0 ? TAG_NONE : TAG_P0;
        end else if (gnt1) begin
            win_addr = bus.addr1;
            push_tag = TAG_P1;
        end else if (gnt2) begin
            win_addr = bus.addr2;
            push_tag = TAG_P2;
        end
    end

    // ------------------------------------------------------------------
    // Registered RAM command, round-robin pointer and lock state.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            rr_prefer2    <= 1'b0;
            owner_q       <= OWN_NONE;
            lock_cnt      <= '0;
        end else begin
            bus.mem_en <= any_gnt;
            bus.mem_we <= gnt0 && bus.we0;
            if (any_gnt) begin
                bus.mem_addr <= win_addr;
            end
            if (gnt0 && bus.we0) begin
                bus.mem_wdata <= bus.wdata0;
            end

            if (gnt1) begin
                rr_prefer2 <= 1'b1;
            end else if (gnt2) begin
                rr_prefer2 <= 1'b0;
            end

            // Inside a binding lock only the owner can be granted, so any
            // reader grant is an owner transfer. Outside it, a locking reader
            // handshake (re)starts the lock at 1; anything else unlocks.
            if (locked_now) begin
                if (gnt1 || gnt2) begin
                    lock_cnt <= lock_cnt + CW'(1);
                end
            end else if (gnt1 && bus.lock1) begin
                owner_q  <= OWN_P1;
                lock_cnt <= CW'(1);
            end else if (gnt2 && bus.lock2) begin
                owner_q  <= OWN_P2;
                lock_cnt <= CW'(1);
            end else begin
                owner_q  <= OWN_NONE;
                lock_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return tag pipeline: stage 0 lines up with mem_en, stage RD_LAT with
    // the cycle mem_rdata is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is reset on purpose; a stale tag would fire an rvalid for a read issued before reset.
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= push_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        tag_live = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            if (tag_q[i] != TAG_NONE) begin
                tag_live = 1'b1;
            end
        end
    end

    assign ret_tag = tag_q[RD_LAT];

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.gnt2    = gnt2;
    assign bus.rvalid0 = (ret_tag == TAG_P0);
    assign bus.rvalid1 = (ret_tag == TAG_P1);
    assign bus.rvalid2 = (ret_tag == TAG_P2);
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : 8'h00;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : 8'h00;
    assign bus.rdata2  = bus.rvalid2 ? bus.mem_rdata : 8'h00;
    assign bus.owner   = owner_q;
    assign bus.busy    = (owner_q != OWN_NONE) || tag_live;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_board_mem_arbiter
//   Directed bench for board_mem_arbiter. Two instances:
//     dut_a : RD_LAT = 1, MAX_LOCK = 32
//     dut_b : RD_LAT = 3, MAX_LOCK = 4
//   Each has a small behavioural RAM whose reset contents are
//   addr[7:0] ^ 8'h5A. Inputs are driven on the falling edge, outputs
//   are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_board_mem_arbiter;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    board_mem_arbiter_if #(.AW(AW)) ifa ();
    board_mem_arbiter_if #(.AW(AW)) ifb ();

    board_mem_arbiter #(.RD_LAT(1), .MAX_LOCK(32), .AW(AW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    board_mem_arbiter #(.RD_LAT(3), .MAX_LOCK(4), .AW(AW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // ---------------- RAM models ----------------
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [7:0] pipe_b1, pipe_b2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram_a[i] <= 8'(i) ^ 8'h5A;
            ifa.mem_rdata <= 8'h00;
        end else if (ifa.mem_en) begin
            if (ifa.mem_we) ram_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
            else            ifa.mem_rdata <= ram_a[ifa.mem_addr[7:0]];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram_b[i] <= 8'(i) ^ 8'h5A;
            pipe_b1       <= 8'h00;
            pipe_b2       <= 8'h00;
            ifb.mem_rdata <= 8'h00;
        end else begin
            if (ifb.mem_en && ifb.mem_we) ram_b[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
            pipe_b1       <= (ifb.mem_en && !ifb.mem_we) ? ram_b[ifb.mem_addr[7:0]] : 8'h00;
            pipe_b2       <= pipe_b1;
            ifb.mem_rdata <= pipe_b2;
        end
    end

    // ---------------- return-strobe monitors ----------------
    int rv1_a = 0;
    int rv2_a = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.rvalid1) rv1_a++;
            if (ifa.rvalid2) rv2_a++;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_val(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic idle_a();
        ifa.req0 = 0; ifa.req1 = 0; ifa.req2 = 0;
        ifa.addr0 = '0; ifa.addr1 = '0; ifa.addr2 = '0;
        ifa.we0 = 0; ifa.wdata0 = '0; ifa.lock1 = 0; ifa.lock2 = 0;
    endtask

    task automatic idle_b();
        ifb.req0 = 0; ifb.req1 = 0; ifb.req2 = 0;
        ifb.addr0 = '0; ifb.addr1 = '0; ifb.addr2 = '0;
        ifb.we0 = 0; ifb.wdata0 = '0; ifb.lock1 = 0; ifb.lock2 = 0;
    endtask

    // Leaves the caller on a falling edge, ready to drive cycle 0.
    task automatic reset_all();
        rst_n = 0;
        idle_a();
        idle_b();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // ---------------- vector tables ----------------
    // Forced-release test on dut_b: inputs {req0, req1, lock1},
    // expected {gnt0, gnt1, owner[1:0]}.
    logic [2:0] t4_in  [9];
    logic [3:0] t4_exp [9];
    // Alternating reads on dut_b: expected {gnt1, gnt2, rvalid1, rvalid2}, rdata1, rdata2.
    logic [3:0] t5_ctl [8];
    logic [7:0] t5_d1  [8];
    logic [7:0] t5_d2  [8];

    initial begin
        t4_in  = '{3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b011, 3'b000, 3'b000};
        t4_exp = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b1001, 4'b0100, 4'b0101, 4'b0001, 4'b0000};
        t5_ctl = '{4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        t5_d1  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3A, 8'h00, 8'h38, 8'h00};
        t5_d2  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 8'h00, 8'h29};
    end

    // ---------------- stimulus ----------------
    initial begin
        int rv1_base, rv2_base;
        int bad_gnt, bad_data;

        // Reset state
        rst_n = 0;
        idle_a();
        idle_b();
        @(negedge clk); #1;
        check("rst_gnt",    {ifa.gnt0, ifa.gnt1, ifa.gnt2}, 0);
        check("rst_mem",    {ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, 0);
        check("rst_rvalid", {ifa.rvalid0, ifa.rvalid1, ifa.rvalid2}, 0);
        check("rst_rdata",  {ifa.rdata0, ifa.rdata1, ifa.rdata2}, 0);
        check("rst_status", {ifa.owner, ifa.busy}, 0);
        check("rst_b",      {ifb.gnt0, ifb.gnt1, ifb.gnt2, ifb.mem_en, ifb.owner, ifb.busy}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single read on port 1, RD_LAT = 1
        ifa.req1 = 1; ifa.addr1 = 16'h0107; #1;
        check("t1_gnt1", ifa.gnt1, 1);
        check("t1_gnt0_gnt2", {ifa.gnt0, ifa.gnt2}, 0);
        @(negedge clk);
        ifa.req1 = 0; #1;
        check("t1_mem_en", ifa.mem_en, 1);
        check("t1_mem_addr", ifa.mem_addr, 16'h0107);
        check("t1_mem_we", ifa.mem_we, 0);
        @(negedge clk); #1;
        check("t1_rvalid1", ifa.rvalid1, 1);
        check("t1_rdata1", ifa.rdata1, 8'h5D);
        check("t1_rvalid2", ifa.rvalid2, 0);
        @(negedge clk); #1;
        check("t1_rvalid1_off", ifa.rvalid1, 0);
        check("t1_busy_off", ifa.busy, 0);

        // Three-way contention: write first, then round-robin readers
        reset_all();
        ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 16'h0010; ifa.wdata0 = 8'hA5;
        ifa.req1 = 1; ifa.addr1 = 16'h0020;
        ifa.req2 = 1; ifa.addr2 = 16'h0030; #1;
        check("t2_c0_gnt", {ifa.gnt0, ifa.gnt1, ifa.gnt2}, 3'b100);
        @(negedge clk);
        ifa.req0 = 0; ifa.we0 = 0; #1;
        check("t2_c1_gnt", {ifa.gnt0, ifa.gnt1, ifa.gnt2}, 3'b010);
        check("t2_c1_wr", {ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, {2'b11, 16'h0010, 8'hA5});
        @(negedge clk);
        ifa.req1 = 0; #1;
        check("t2_c2_gnt", {ifa.gnt0, ifa.gnt1, ifa.gnt2}, 3'b001);
        check("t2_c2_addr", {ifa.mem_we, ifa.mem_addr}, {1'b0, 16'h0020});
        @(negedge clk);
        ifa.req2 = 0; #1;
        check("t2_c3_ret1", {ifa.rvalid1, ifa.rvalid2, ifa.rdata1}, {2'b10, 8'h7A});
        @(negedge clk); #1;
        check("t2_c4_ret2", {ifa.rvalid1, ifa.rvalid2, ifa.rdata2}, {2'b01, 8'h6A});
        @(negedge clk);
        ifa.req1 = 1; ifa.addr1 = 16'h0010; #1;
        check("t2_raw_gnt", ifa.gnt1, 1);
        @(negedge clk);
        ifa.req1 = 0;
        @(negedge clk); #1;
        check("t2_raw_data", {ifa.rvalid1, ifa.rdata1}, {1'b1, 8'hA5});

        // 25-read locked burst on port 1, write raised at read 5
        rv1_base = rv1_a;
        rv2_base = rv2_a;
        bad_gnt  = 0;
        bad_data = 0;
        @(negedge clk);
        ifa.lock1 = 1; ifa.req1 = 1;
        for (int i = 1; i <= 25; i++) begin
            ifa.addr1 = 16'h0040 + 16'(i);
            if (i == 5) begin
                ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 16'h0080; ifa.wdata0 = 8'h3C;
            end
            #1;
            if (!ifa.gnt1 || ifa.gnt0 || ifa.gnt2) bad_gnt++;
            if (i >= 3 && (!ifa.rvalid1 || ifa.rdata1 !== exp_val(16'h0040 + 16'(i - 2)))) bad_data++;
            if (i == 10) check("t3_owner_locked", {ifa.owner, ifa.busy}, {2'd1, 1'b1});
            @(negedge clk);
        end
        ifa.lock1 = 0; ifa.req1 = 0; #1;
        check("t3_burst_gnt", bad_gnt, 0);
        check("t3_burst_data", bad_data, 0);
        check("t3_drop_gnt", {ifa.gnt0, ifa.gnt1, ifa.gnt2}, 3'b100);
        check("t3_drop_owner", ifa.owner, 1);
        @(negedge clk);
        ifa.req0 = 0; ifa.we0 = 0; #1;
        check("t3_owner_free", ifa.owner, 0);
        check("t3_write", {ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, {2'b11, 16'h0080, 8'h3C});
        repeat (3) @(negedge clk);
        #1;
        check("t3_rvalid1_count", rv1_a - rv1_base, 25);
        check("t3_rvalid2_count", rv2_a - rv2_base, 0);

        // Forced release after MAX_LOCK = 4 owner transfers (dut_b)
        @(negedge clk);
        ifb.addr0 = 16'h0090; ifb.we0 = 1; ifb.wdata0 = 8'h77;
        for (int c = 0; c < 9; c++) begin
            {ifb.req0, ifb.req1, ifb.lock1} = t4_in[c];
            ifb.addr1 = 16'h0050 + 16'(c);
            #1;
            check($sformatf("t4_c%0d", c), {ifb.gnt0, ifb.gnt1, ifb.owner}, t4_exp[c]);
            if (c == 5) check("t4_write", {ifb.mem_we, ifb.mem_addr}, {1'b1, 16'h0090});
            @(negedge clk);
        end

        // Alternating readers, RD_LAT = 3 (dut_b)
        reset_all();
        for (int c = 0; c < 8; c++) begin
            ifb.req1  = (c < 4);
            ifb.req2  = (c < 4);
            ifb.addr1 = 16'h0060 + 16'(c);
            ifb.addr2 = 16'h0070 + 16'(c);
            #1;
            check($sformatf("t5_c%0d", c),
                  {ifb.gnt1, ifb.gnt2, ifb.rvalid1, ifb.rvalid2, ifb.rdata1, ifb.rdata2},
                  {t5_ctl[c], t5_d1[c], t5_d2[c]});
            @(negedge clk);
        end

        // Reset with reads in flight and a lock held (dut_a)
        ifa.lock1 = 1; ifa.req1 = 1; ifa.addr1 = 16'h0001; #1;
        check("t6_c0_gnt", ifa.gnt1, 1);
        @(negedge clk);
        ifa.addr1 = 16'h0002; #1;
        check("t6_c1_gnt", ifa.gnt1, 1);
        @(negedge clk); #1;
        check("t6_pre_rst", {ifa.owner, ifa.busy, ifa.rvalid1}, {2'd1, 1'b1, 1'b1});
        rv1_base = rv1_a;
        rst_n = 0; #1;
        check("t6_rst_gnt", {ifa.gnt0, ifa.gnt1, ifa.gnt2}, 0);
        check("t6_rst_ret", {ifa.rvalid1, ifa.rdata1}, 0);
        check("t6_rst_status", {ifa.owner, ifa.busy, ifa.mem_en}, 0);
        @(negedge clk);
        idle_a();
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        #1;
        check("t6_no_late_rvalid", rv1_a - rv1_base, 0);
        check("t6_owner_after", {ifa.owner, ifa.busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
